// File: rtl/arb_rr4_dec.sv
// Four-way round-robin arbiter. The grant is presented as a 2-to-4 decoder
// control set (oC/oS0/oS1) together with the decoded one-cold grant vector.
module arb_rr4_dec #(
  parameter int MAX_HOLD = 8
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [3:0] iReq,
  input  logic       iDone,
  output logic       oC,
  output logic       oS0,
  output logic       oS1,
  output logic [3:0] oGnt_n,
  output logic       oBusy,
  output logic       oTimeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [0:0] r_state;
  logic [1:0] r_last;
  logic [3:0] r_cnt;
  logic       r_c;
  logic       r_s0;
  logic       r_s1;
  logic [3:0] r_gnt_n;
  logic       r_busy;
  logic       r_timeout;

  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_owner;
  logic       w_hitMax;
  logic       w_reqLost;
  logic       w_release;

  // Scan from farthest to nearest so the nearest set bit after LAST wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (iReq[r_last + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_last + 2'(k);
      end
    end
  end

  assign w_owner   = {r_s0, r_s1};
  assign w_hitMax  = (r_cnt == HOLD_LAST);
  assign w_reqLost = ~iReq[w_owner];
  assign w_release = iDone | w_reqLost | w_hitMax;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state   <= IDLE;
      r_last    <= 2'd3;
      r_cnt     <= 4'd0;
      r_c       <= 1'b1;
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_gnt_n   <= 4'b1111;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_found) begin
            r_state <= GRANT;
            r_cnt   <= 4'd0;
            r_c     <= 1'b0;
            r_s0    <= w_win[1];
            r_s1    <= w_win[0];
            r_gnt_n <= ~(4'b0001 << w_win);
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state   <= IDLE;
            r_last    <= w_owner;
            r_cnt     <= 4'd0;
            r_c       <= 1'b1;
            r_gnt_n   <= 4'b1111;
            r_busy    <= 1'b0;
            // Only a pure hold-limit expiry counts as a timeout.
            r_timeout <= w_hitMax & ~iDone & ~w_reqLost;
          end else begin
            r_cnt     <= r_cnt + 4'd1;
            r_timeout <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oC       = r_c;
  assign oS0      = r_s0;
  assign oS1      = r_s1;
  assign oGnt_n   = r_gnt_n;
  assign oBusy    = r_busy;
  assign oTimeout = r_timeout;

endmodule

// File: doc/arb_rr4_dec.md
ARB_RR4_DEC -- requirements
Module: arb_rr4_dec

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum cycles one grant is held before forced release; legal range 2..15.
REQ-002 iClk  input  1  sole clock, all state updates on rising edge.
REQ-003 iRst_n  input  1  reset, synchronous, active-low.
REQ-004 iReq  input  4  request from requester k on bit k, level-held until served.
REQ-005 iDone  input  1  current owner finished, sampled only in GRANT.
REQ-006 oC  output  1  active-low enable to the 2-to-4 active-low decoder.
REQ-007 oS0  output  1  decoder select MSB; equals winner index bit 1.
REQ-008 oS1  output  1  decoder select LSB; equals winner index bit 0.
REQ-009 oGnt_n  output  4  active-low one-cold grant, bit k low = requester k owns resource.
REQ-010 oBusy  output  1  high while in GRANT.
REQ-011 oTimeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 States SHALL be IDLE and GRANT only.
REQ-014 Round-robin pointer LAST (2 bits) SHALL hold the index of the most recently served requester.
REQ-015 In IDLE with iReq != 0, winner SHALL be the first set bit scanning LAST+1, LAST+2, LAST+3, LAST (mod 4, wrap 3 -> 0); next state GRANT.
REQ-016 In IDLE with iReq == 0, state, LAST and outputs SHALL hold.
REQ-017 Grant latency: request sampled at edge N SHALL produce oGnt_n, oC=0, oBusy=1 after edge N (one cycle).
REQ-018 In GRANT: oC=0, {oS0,oS1}=winner, oGnt_n[winner]=0, other bits 1; oGnt_n SHALL always equal the decoder output for the driven oC/oS0/oS1.
REQ-019 Hold counter SHALL be 0 on GRANT entry and increment each GRANT cycle.
REQ-020 Release SHALL occur when iDone=1, or iReq[winner]=0, or counter == MAX_HOLD-1; next state IDLE, LAST <= winner, counter <= 0.
REQ-021 On release, oC=1, oGnt_n=4'b1111, oBusy=0 after the same edge; at least one idle cycle SHALL separate consecutive grants.
REQ-022 oTimeout SHALL pulse high for exactly one cycle only when release is caused solely by counter == MAX_HOLD-1; iDone=1 or request drop at the same edge SHALL suppress it.
REQ-023 Changes on iReq bits other than winner during GRANT SHALL be ignored.
REQ-024 oS0/oS1 SHALL retain the last winner value in IDLE.

Reset
REQ-025 iRst_n=0 at a rising edge SHALL force: state IDLE, LAST=3, counter=0, oC=1, oS0=0, oS1=0, oGnt_n=4'b1111, oBusy=0, oTimeout=0.
REQ-026 Reset SHALL override every other condition, including mid-GRANT; no grant SHALL be held after the reset edge.
REQ-027 After reset release with all requesters active, requester 0 SHALL be served first.

Verification
REQ-028 Reset then iReq=4'b1111 held, iDone pulsed each grant -> grant order 0,1,2,3,0; oGnt_n = 1110,1101,1011,0111; {oS0,oS1}=00,01,10,11.
REQ-029 iReq=4'b0100 one cycle after reset -> next cycle oGnt_n=1011, oC=0, oS0=1, oS1=0, oBusy=1.
REQ-030 MAX_HOLD=8, iReq=4'b0010 held, iDone=0 -> grant for 8 cycles, oTimeout=1 one cycle at release, then IDLE one cycle, re-grant to 1.
REQ-031 iDone=1 on the same edge counter == MAX_HOLD-1 -> release, oTimeout stays 0.
REQ-032 LAST=3, iReq=4'b1000 then 4'b1001 -> wrap: requester 0 served before 3 on the second arbitration.
REQ-033 iRst_n=0 during GRANT to requester 2 -> next cycle oGnt_n=1111, oC=1, oBusy=0; with iReq=4'b1111 afterwards, requester 0 granted first.
